// File: rtl/j1_uart_io.sv
// j1_uart_io: memory-mapped UART peripheral on the j1 IO bus
// Ports: clk, reset (sync, active-high)
//        io_rd, io_wr, io_addr, io_dout : IO bus read/write strobes, address, CPU write data
//        io_din            : registered read data, holds until the next io_rd
//        interrupt_request : rx_irq_en & RX FIFO non-empty
//        uart_rx           : asynchronous serial input, idle high
//        uart_tx           : serial output, idle high
module j1_uart_io #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          RXFIFO_DEPTH = 16,
    parameter logic [15:0] DATA_ADDR    = 16'h1000,
    parameter logic [15:0] STATUS_ADDR  = 16'h2000,
    parameter logic [15:0] CTRL_ADDR    = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        interrupt_request,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(RXFIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
    localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT = 3'd4;

    logic          rx_irq_en, overflow, framing_err, hold_full;
    logic [7:0]    hold_data, tx_shift, rx_shift;
    logic [1:0]    tx_state;
    logic [2:0]    rx_state, tx_bit, rx_bit;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          rx_s1, rx_s2, rx_prev;
    logic [7:0]    fifo [RXFIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, push, push_ok, stop_bad, tx_reload;
    logic          unused;

    assign unused            = ^io_dout[15:8];
    assign empty             = wptr == rptr;
    assign full              = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop               = io_rd && io_addr == DATA_ADDR && !empty;
    assign push              = rx_state == RX_STOP && rx_cnt == LAST && rx_s2;
    assign stop_bad          = rx_state == RX_STOP && rx_cnt == LAST && !rx_s2;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign push_ok           = push && (!full || pop);
    assign interrupt_request = rx_irq_en && !empty;
    // start a frame from IDLE, or straight out of STOP for back-to-back bytes
    assign tx_reload         = hold_full && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            uart_tx   <= 1'b1;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (io_wr && io_addr == DATA_ADDR && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= io_dout[7:0];
            end
            tx_cnt <= (tx_state == TX_IDLE || tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
            if (tx_reload) begin
                tx_state  <= TX_START;
                tx_shift  <= hold_data;
                hold_full <= 1'b0;
                uart_tx   <= 1'b0;
            end else if (tx_cnt == LAST && tx_state == TX_STOP) begin
                tx_state <= TX_IDLE;
            end else if (tx_cnt == LAST && tx_state == TX_START) begin
                tx_state <= TX_DATA;
                tx_bit   <= '0;
                uart_tx  <= tx_shift[0];
            end else if (tx_cnt == LAST && tx_state == TX_DATA) begin
                tx_bit   <= tx_bit + 3'd1;
                tx_shift <= tx_shift >> 1;
                uart_tx  <= tx_bit == 3'd7 ? 1'b1 : tx_shift[1];
                tx_state <= tx_bit == 3'd7 ? TX_STOP : TX_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_cnt  <= rx_cnt + CW'(1);
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= RX_START;
                end
                // half a bit in: a line back at 1 means the edge was a glitch
                RX_START: if (rx_cnt == HALF) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt == LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    rx_state <= rx_bit == 3'd7 ? RX_STOP : RX_DATA;
                end
                RX_STOP: if (rx_cnt == LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
                end
                RX_WAIT: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_din      <= '0;
            rx_irq_en   <= 1'b0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            if (io_rd)
                io_din <= io_addr == DATA_ADDR   ? (empty ? 16'h0000 : {8'h00, fifo[rptr[AW-1:0]]}) :
                          io_addr == STATUS_ADDR ? {12'h000, framing_err, overflow, !empty, !hold_full} :
                          io_addr == CTRL_ADDR   ? {15'h0000, rx_irq_en} : 16'h0000;
            if (pop) rptr <= rptr + (AW+1)'(1);
            if (push_ok) wptr <= wptr + (AW+1)'(1);
            if (io_wr && io_addr == CTRL_ADDR) rx_irq_en <= io_dout[0];
            if (io_wr && io_addr == STATUS_ADDR && io_dout[2]) overflow <= 1'b0;
            if (io_wr && io_addr == STATUS_ADDR && io_dout[3]) framing_err <= 1'b0;
            if (push && full && !pop) overflow <= 1'b1;
            if (stop_bad) framing_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: self-checking bench for j1_uart_io with a frame/queue level reference model
module tb_j1_uart_io;
    localparam int CPB = 104;
    localparam logic [15:0] A_DATA = 16'h1000, A_STAT = 16'h2000, A_CTRL = 16'h4000;

    logic        clk = 1'b0, reset = 1'b1, io_rd = 1'b0, io_wr = 1'b0, uart_rx = 1'b1;
    logic [15:0] io_addr = '0, io_dout = '0;
    logic [15:0] io_din;
    logic        interrupt_request, uart_tx;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    j1_uart_io dut (
        .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(io_din), .interrupt_request(interrupt_request),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    // reference model: frames are (start edge, byte) pairs; RX bytes arrive whole from the driver
    int          cyc = 0;
    bit          m_valid = 0, rx_busy = 0;
    int          f_start[$];
    logic [7:0]  f_byte[$];
    int          hold_w = -1, hold_s = -1;
    logic [7:0]  m_fifo[$];
    logic [8:0]  rx_q[$];
    logic        m_ovf = 0, m_ferr = 0, m_irq_en = 0;
    logic [15:0] m_din = '0;

    function automatic logic tx_exp(int n);
        for (int i = 0; i < f_start.size(); i++)
            if (n >= f_start[i] && n < f_start[i] + 10 * CPB) begin
                int k = (n - f_start[i]) / CPB;
                return k == 0 ? 1'b0 : k == 9 ? 1'b1 : f_byte[i][k-1];
            end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int n, s;
        logic rdy;
        logic [8:0] r;
        cyc++;
        n = cyc;
        if (reset) begin
            m_valid = 1; m_din = '0; m_ovf = 0; m_ferr = 0; m_irq_en = 0;
            m_fifo.delete(); f_start.delete(); f_byte.delete(); rx_q.delete();
            hold_w = -1; hold_s = -1;
        end else begin
            rdy = !(n - 1 >= hold_w && n - 1 < hold_s);
            if (io_rd) begin
                if (io_addr == A_DATA) begin
                    if (m_fifo.size() > 0) m_din = {8'h00, m_fifo.pop_front()};
                    else m_din = 16'h0000;
                end else if (io_addr == A_STAT) m_din = {12'h000, m_ferr, m_ovf, m_fifo.size() > 0, rdy};
                else if (io_addr == A_CTRL) m_din = {15'h0000, m_irq_en};
                else m_din = 16'h0000;
            end
            if (io_wr && io_addr == A_DATA && rdy) begin
                s = f_start.size() > 0 ? f_start[$] + 10 * CPB : 0;
                if (s < n + 1) s = n + 1;
                f_start.push_back(s);
                f_byte.push_back(io_dout[7:0]);
                hold_w = n;
                hold_s = s;
            end
            if (io_wr && io_addr == A_STAT) begin
                if (io_dout[2]) m_ovf = 0;
                if (io_dout[3]) m_ferr = 0;
            end
            if (io_wr && io_addr == A_CTRL) m_irq_en = io_dout[0];
            while (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                if (!r[8]) m_ferr = 1;
                else if (m_fifo.size() == 16) m_ovf = 1;
                else m_fifo.push_back(r[7:0]);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("uart_tx", {15'h0, uart_tx}, {15'h0, tx_exp(cyc)});
            check("io_din", io_din, m_din);
            if (!rx_busy) check("irq", {15'h0, interrupt_request}, {15'h0, m_irq_en && m_fifo.size() > 0});
        end
    end

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        io_rd = 1; io_addr = a;
        @(negedge clk);
        io_rd = 0;
        d = io_din;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        io_wr = 1; io_addr = a; io_dout = v;
        @(negedge clk);
        io_wr = 0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input bit chk);
        rx_busy = 1;
        uart_rx = 0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        if (chk) begin
            repeat (4) @(negedge clk);
            check("irq_before_stop", {15'h0, interrupt_request}, 16'h0000);
            repeat (CPB - 4) @(negedge clk);
        end else repeat (CPB) @(negedge clk);
        uart_rx = 1;
        if (!stop) repeat (CPB) @(negedge clk);
        rx_q.push_back({stop, b});
        @(negedge clk);
        rx_busy = 0;
    endtask

    initial begin
        logic [15:0] d;
        int t0, s1;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_tx", {15'h0, uart_tx}, 16'h0001);
        check("rst_irq", {15'h0, interrupt_request}, 16'h0000);
        rd(A_STAT, d); check("rst_status", d, 16'h0001);

        wr(A_DATA, 16'h0055); t0 = cyc;
        rd(A_STAT, d); check("tx_hold_busy", d, 16'h0000);
        rd(A_STAT, d); check("tx_hold_free", d, 16'h0001);
        for (int k = 0; k < 10; k++) begin
            wait_to(t0 + 1 + k * CPB + CPB / 2);
            check("tx55_bit", {15'h0, uart_tx}, 16'(k % 2));
        end
        wait_to(t0 + 1 + 10 * CPB + 2);

        wr(A_DATA, 16'h0041); t0 = cyc;
        @(negedge clk);
        wr(A_DATA, 16'h0042);
        wr(A_DATA, 16'h0043);
        rd(A_STAT, d); check("hold_full", d, 16'h0000);
        s1 = t0 + 1;
        wait_to(s1 + 10 * CPB - 1); check("f1_stop", {15'h0, uart_tx}, 16'h0001);
        wait_to(s1 + 10 * CPB); check("f2_start_nogap", {15'h0, uart_tx}, 16'h0000);
        wait_to(s1 + 12 * CPB + CPB / 2); check("f2_bit1", {15'h0, uart_tx}, 16'h0001);
        wait_to(s1 + 20 * CPB + CPB / 2); check("no_third_frame", {15'h0, uart_tx}, 16'h0001);

        wr(A_CTRL, 16'h0001);
        rd(A_CTRL, d); check("ctrl_rd", d, 16'h0001);
        rx_send(8'hA5, 1'b1, 1'b1);
        check("irq_after_rx", {15'h0, interrupt_request}, 16'h0001);
        rd(A_DATA, d); check("rx_a5", d, 16'h00A5);
        check("irq_after_pop", {15'h0, interrupt_request}, 16'h0000);

        for (int i = 0; i < 17; i++) rx_send(8'(i), 1'b1, 1'b0);
        rd(A_STAT, d); check("ovf_status", d, 16'h0007);
        for (int i = 0; i < 16; i++) begin
            rd(A_DATA, d); check("fifo_order", d, 16'(i));
        end
        rd(A_DATA, d); check("empty_read", d, 16'h0000);
        wr(A_STAT, 16'h0004);
        rd(A_STAT, d); check("ovf_cleared", d, 16'h0001);

        rx_send(8'h3C, 1'b0, 1'b0);
        rd(A_STAT, d); check("ferr_status", d, 16'h0009);
        wr(A_STAT, 16'h0008);
        rd(A_STAT, d); check("ferr_cleared", d, 16'h0001);

        rx_busy = 1; uart_rx = 0;
        @(negedge clk);
        uart_rx = 1;
        repeat (2 * CPB) @(negedge clk);
        rx_busy = 0;
        rd(A_STAT, d); check("glitch_no_byte", d, 16'h0001);

        wr(A_DATA, 16'h0000);
        repeat (3 * CPB) @(negedge clk);
        check("tx_low_midframe", {15'h0, uart_tx}, 16'h0000);
        reset = 1;
        @(negedge clk);
        check("tx_reset_abort", {15'h0, uart_tx}, 16'h0001);
        reset = 0;
        rd(A_CTRL, d); check("ctrl_after_reset", d, 16'h0000);
        rd(A_STAT, d); check("status_after_reset", d, 16'h0001);
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/j1_uart_io.md
Name: j1_uart_io

Overview:
- Memory-mapped UART peripheral on the j1 IO bus.
- Decodes io_rd/io_wr/io_addr/io_dout and returns registered read data on io_din.
- Drives the CPU's level-sensitive interrupt_request while receive data is pending and the interrupt is enabled.
- Contains a 1-byte TX holding register, a bit-serial transmitter, an oversampled receiver and an RX FIFO.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); must be at least 4.
- RXFIFO_DEPTH, 16, RX FIFO entries; must be a power of 2 and at least 2.
- DATA_ADDR, 16'h1000, UART data register address.
- STATUS_ADDR, 16'h2000, status/clear register address.
- CTRL_ADDR, 16'h4000, control register address (bit0 = rx_irq_en).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- io_rd  in  1  IO read strobe, one cycle.
- io_wr  in  1  IO write strobe, one cycle.
- io_addr  in  16  IO address, full 16-bit compare.
- io_dout  in  16  CPU write data.
- io_din  out  16  registered read data to the CPU.
- interrupt_request  out  1  level IRQ = rx_irq_en & rx_nonempty.
- uart_rx  in  1  asynchronous serial input, idle high.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Reset (synchronous, while reset=1): uart_tx=1, io_din=0, interrupt_request=0, FIFO empty, holding register empty, TX and RX FSMs in IDLE, rx_irq_en=0, sticky flags cleared.
- A reset asserted mid-frame aborts the frame immediately; uart_tx returns to 1 on the next edge.
- Read timing: io_din is loaded at the clock edge where io_rd=1 and then holds until the next io_rd. The CPU consumes it on the following instruction.
- Read of DATA_ADDR:
  - io_din = {8'h00, FIFO head}, and the FIFO pops.
  - If the FIFO is empty: io_din = 16'h0000 and no pop.
- Read of STATUS_ADDR: io_din = {12'b0, framing_err, overflow, rx_nonempty, tx_ready}.
  - tx_ready = holding register empty.
- Read of CTRL_ADDR: io_din = {15'b0, rx_irq_en}.
- Read of any unmapped address: io_din = 0.
- Write to DATA_ADDR:
  - If tx_ready=1: io_dout[7:0] is latched into the holding register.
  - Otherwise the write is dropped with no flag.
- Write to STATUS_ADDR: io_dout[2]=1 clears overflow; io_dout[3]=1 clears framing_err (write-1-to-clear).
- Write to CTRL_ADDR: rx_irq_en = io_dout[0].
- io_rd and io_wr asserted in the same cycle: both actions take effect.
- TX FSM states: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts exactly CLKS_PER_BIT cycles.
  - IDLE moves to START the cycle after the holding register is full; the holding register empties on that transition, so the CPU can queue the next byte during the frame.
  - Back-to-back bytes: the next START begins immediately after STOP, with no idle bit.
- RX input: uart_rx passes through a 2-FF synchroniser, initialised to 1 on reset.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge starts a half-bit count (CLKS_PER_BIT/2).
  - START: the sample is re-checked at mid-bit; if it is 1 (glitch), return to IDLE.
  - DATA: 8 samples taken at CLKS_PER_BIT spacing, LSB first.
  - STOP: sampled at mid-bit.
    - Stop=1: push the byte.
    - Stop=0: discard the byte, set framing_err, and wait for the line to return to 1 before IDLE.
- FIFO full on push: the byte is dropped and overflow is set sticky; FIFO contents are unchanged.
- Simultaneous push and pop: both succeed, including when the FIFO is full (the pop frees the slot).
- FIFO pointers are log2(RXFIFO_DEPTH)+1 bits wide and wrap naturally.
- interrupt_request is combinational from registers: it deasserts in the cycle after the pop that empties the FIFO.

Test Plan:
- Reset release -> uart_tx=1, interrupt_request=0. Read STATUS -> io_din=16'h0001.
- Write DATA=16'h0055 -> uart_tx carries 0,1,0,1,0,1,0,1,0,1 (start, LSB-first 0x55, stop), each bit 104 cycles. STATUS bit0=0 only until the START transition.
- Write 0x41 then immediately 0x42 -> two contiguous frames with no idle gap. A third write during frame 1, after 0x42 is queued, is dropped.
- Drive serial 0xA5 on uart_rx with rx_irq_en=1 -> interrupt_request rises after the stop-bit sample. Read DATA -> io_din=16'h00A5, interrupt_request=0 the next cycle.
- Send 17 bytes 0x00..0x10 without reading -> STATUS bit2=1. 16 DATA reads return 0x00..0x0F; a 17th read returns 0. Write STATUS=16'h0004 -> bit2=0.
- Frame with stop bit=0 -> no FIFO push, STATUS bit3=1. A 1-cycle low glitch on uart_rx produces no byte. Reset asserted mid-TX-frame -> uart_tx=1 on the next edge.
